// File: rtl/imm_gen_stage.sv
// RV32I/RV64I immediate generator stage between IF/ID and ID/EX.
// Decodes on the input side and stores results in a 2-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_U   = 3'd4;
  localparam logic [2:0] F_J   = 3'd5;
  localparam logic [2:0] F_SH  = 3'd6;
  localparam logic [2:0] F_ILL = 3'd7;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_OP  = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  entry_t     dec;
  entry_t     main_q;
  entry_t     skid_q;
  logic       main_v;
  logic       skid_v;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [5:0] shamt;
  logic       accept;
  logic       pop;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  // RV32 shift amounts are only 5 bits wide
  assign shamt = (XLEN == 64) ? instr_i[25:20]
                              : {1'b0, instr_i[24:20]};

  always_comb begin
    dec       = '0;
    dec.pc    = pc_i;
    dec.instr = instr_i;
    unique case (1'b1)
      (opc == OP_IMM): begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.fmt = F_SH;
          dec.imm = XLEN'(shamt);
        end else begin
          dec.fmt = F_I;
          dec.imm = sext({{20{instr_i[31]}}, instr_i[31:20]});
        end
      end
      (opc == OP_LD),
      (opc == OP_JLR): begin
        dec.fmt = F_I;
        dec.imm = sext({{20{instr_i[31]}}, instr_i[31:20]});
      end
      (opc == OP_ST): begin
        dec.fmt = F_S;
        dec.imm = sext({{20{instr_i[31]}},
                        instr_i[31:25], instr_i[11:7]});
      end
      (opc == OP_BR): begin
        dec.fmt = F_B;
        dec.imm = sext({{19{instr_i[31]}}, instr_i[31],
                        instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0});
      end
      (opc == OP_LUI),
      (opc == OP_AUI): begin
        dec.fmt = F_U;
        dec.imm = sext({instr_i[31:12], 12'b0});
      end
      (opc == OP_JAL): begin
        dec.fmt = F_J;
        dec.imm = sext({{11{instr_i[31]}}, instr_i[31],
                        instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0});
      end
      (opc == OP_OP): begin
        dec.fmt = F_R;
      end
      default: begin
        dec.fmt = F_ILL;
        dec.ill = 1'b1;
      end
    endcase
  end

  assign in_ready_o = !skid_v;
  assign accept     = in_valid_i & !skid_v;
  assign pop        = main_v & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (accept && pop) begin
      // skid is empty here, so main is the only entry
      main_q <= dec;
    end else if (accept) begin
      if (!main_v) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end else if (pop) begin
      if (skid_v) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else begin
        main_v <= 1'b0;
      end
    end
  end

  assign out_valid_o = main_v;
  assign imm_o       = main_q.imm;
  assign fmt_o       = main_q.fmt;
  assign illegal_o   = main_q.ill;
  assign pc_o        = main_q.pc;
  assign instr_o     = main_q.instr;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        illegal;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  logic        v64;
  logic        rdy64;
  logic [31:0] instr64;
  logic [63:0] pc64;
  logic        ordy64;
  logic        ov64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        ill64;
  logic [63:0] pcq64;
  logic [31:0] iq64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .imm_o(imm), .fmt_o(fmt), .illegal_o(illegal),
    .pc_o(pc_q), .instr_o(instr_q)
  );

  imm_gen_stage #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(v64), .in_ready_o(rdy64),
    .instr_i(instr64), .pc_i(pc64),
    .out_valid_o(ov64), .out_ready_i(ordy64),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64),
    .pc_o(pcq64), .instr_o(iq64)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s_ins [4];
  logic [31:0] s_imm [4];
  logic [2:0]  s_fmt [4];

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; instr = '0; pc = '0; out_ready = 1'b0;
    v64 = 1'b0; instr64 = '0; pc64 = '0; ordy64 = 1'b0;
    tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_instr", instr_q, 0);
    chk("rst64_imm", imm64, 0);
    rst = 1'b0;
    tick;

    // single addi
    in_valid = 1'b1; instr = 32'hFFF00093; pc = 32'h100;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_fmt", fmt, 1);
    chk("addi_ill", illegal, 0);
    chk("addi_pc", pc_q, 32'h100);
    tick;
    chk("drain_valid", out_valid, 0);

    // back-to-back stream, then shifts and illegal
    s_ins = '{32'hFE20AE23, 32'hFE000CE3, 32'hFFDFF06F, 32'h123452B7};
    s_imm = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000};
    s_fmt = '{3'd2, 3'd3, 3'd5, 3'd4};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = s_ins[i];
      chk("strm_ready", in_ready, 1);
      tick;
      chk("strm_imm", imm, s_imm[i]);
      chk("strm_fmt", fmt, s_fmt[i]);
      chk("strm_instr", instr_q, s_ins[i]);
    end
    s_ins = '{32'h01F09093, 32'h4030D093, 32'h0000007F, 32'h00000033};
    s_imm = '{32'h1F, 32'h3, 32'h0, 32'h0};
    s_fmt = '{3'd6, 3'd6, 3'd7, 3'd0};
    for (int i = 0; i < 4; i++) begin
      instr = s_ins[i];
      tick;
      chk("shill_imm", imm, s_imm[i]);
      chk("shill_fmt", fmt, s_fmt[i]);
      chk("shill_ill", illegal, (i == 2) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick;
    chk("drain2_valid", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093;
    tick;
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_ready", in_ready, 1);
    instr = 32'h00200113;
    tick;
    chk("bp_b_ready", in_ready, 0);
    chk("bp_b_hold", instr_q, 32'h00100093);
    instr = 32'h00300193;
    tick;
    chk("bp_c_ready", in_ready, 0);
    chk("bp_c_hold", instr_q, 32'h00100093);
    chk("bp_c_imm", imm, 1);
    out_ready = 1'b1;
    tick;
    chk("bp_out_b", instr_q, 32'h00200113);
    chk("bp_ready_back", in_ready, 1);
    tick;
    in_valid = 1'b0;
    chk("bp_out_c", instr_q, 32'h00300193);
    chk("bp_imm_c", imm, 3);
    tick;
    chk("bp_empty", out_valid, 0);

    // flush with two held entries
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00100093;
    tick;
    instr = 32'h00200113;
    tick;
    chk("fl_full", in_ready, 0);
    flush = 1'b1; instr = 32'h00400213;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    tick;
    chk("fl_gone", out_valid, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00500293; pc = 32'h2000;
    tick;
    in_valid = 1'b0;
    chk("ar_pre", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_imm", imm, 0);
    chk("ar_pc", pc_q, 0);
    chk("ar_instr", instr_q, 0);
    chk("ar_ready", in_ready, 1);
    tick;
    rst = 1'b0;
    tick;
    chk("ar_after", out_valid, 0);

    // XLEN=64 instance
    ordy64 = 1'b1;
    v64 = 1'b1; instr64 = 32'h800002B7; pc64 = 64'h1_0000_0040;
    tick;
    chk("x64_lui", imm64, 64'hFFFFFFFF80000000);
    chk("x64_pc", pcq64, 64'h1_0000_0040);
    chk("x64_fmt", fmt64, 4);
    instr64 = 32'h03F09093; pc64 = 64'h1_0000_0044;
    tick;
    v64 = 1'b0;
    chk("x64_slli", imm64, 64'h3F);
    chk("x64_shfmt", fmt64, 6);
    chk("x64_pc2", pcq64, 64'h1_0000_0044);
    tick;
    chk("x64_drain", ov64, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
